// File: rtl/cp0_exception_ctrl_if.sv
// cp0_exception_ctrl_if: datapath, CP0 register-file and fetch-redirect signals of the exception controller
interface cp0_exception_ctrl_if;
  logic [5:0]  hwInt;
  logic [31:0] pc;
  logic        eret;
  logic [4:0]  dpRegNum;
  logic [31:0] dpDin;
  logic [1:0]  dpWEn;
  logic [31:0] cp0Dout;
  logic [4:0]  cp0RegNum;
  logic [31:0] cp0Din;
  logic [1:0]  cp0WEn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPC;
  modport master (
    output hwInt, pc, eret, dpRegNum, dpDin, dpWEn, cp0Dout,
    input  cp0RegNum, cp0Din, cp0WEn, stall, redirect, redirectPC
  );
  modport slave (
    input  hwInt, pc, eret, dpRegNum, dpDin, dpWEn, cp0Dout,
    output cp0RegNum, cp0Din, cp0WEn, stall, redirect, redirectPC
  );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: sequences interrupt entry (EPC/Cause/Status writes) and ERET return over the CP0 port
module cp0_exception_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input logic                 clk,
  input logic                 rst,
  cp0_exception_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, E_RD, E_WR, REDIR} state_e;
  state_e      state_q, state_d;
  logic [31:0] shadow_q, epc_q, target_q, rpc_q;
  logic [5:0]  int_q, pend;
  logic        take;
  logic [4:0]  reg_num;
  logic [31:0] din;
  logic [1:0]  wen;
  logic        stall, redirect;
  assign pend = bus.hwInt & shadow_q[15:10];
  assign take = (|pend) & shadow_q[0] & ~shadow_q[1];
  always_comb begin
    state_d  = state_q;
    reg_num  = bus.dpRegNum;
    din      = bus.dpDin;
    wen      = bus.dpWEn;
    stall    = 1'b0;
    redirect = 1'b0;
    case (state_q)
      IDLE: if (take || bus.eret) begin
        stall   = 1'b1;
        wen     = 2'b00;
        state_d = take ? W_EPC : E_RD;
      end
      W_EPC: begin
        reg_num = 5'd14;
        din     = epc_q;
        wen     = 2'b01;
        stall   = 1'b1;
        state_d = W_CAUSE;
      end
      W_CAUSE: begin
        reg_num = 5'd13;
        din     = {16'b0, int_q, 10'b0};
        wen     = 2'b01;
        stall   = 1'b1;
        state_d = W_STATUS;
      end
      W_STATUS: begin
        reg_num = 5'd12;
        din     = shadow_q | 32'h2;
        wen     = 2'b01;
        stall   = 1'b1;
        state_d = REDIR;
      end
      E_RD: begin
        reg_num = 5'd14;
        wen     = 2'b00;
        stall   = 1'b1;
        state_d = E_WR;
      end
      E_WR: begin
        reg_num = 5'd12;
        din     = shadow_q & ~32'h2;
        wen     = 2'b01;
        stall   = 1'b1;
        state_d = REDIR;
      end
      REDIR: begin
        wen      = 2'b00;
        redirect = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset abandons any in-flight sequence immediately, including this cycle's CP0 write
    if (rst) begin
      reg_num  = bus.dpRegNum;
      din      = bus.dpDin;
      wen      = bus.dpWEn;
      stall    = 1'b0;
      redirect = 1'b0;
    end
  end
  assign bus.cp0RegNum  = reg_num;
  assign bus.cp0Din     = din;
  assign bus.cp0WEn     = wen;
  assign bus.stall      = stall;
  assign bus.redirect   = redirect;
  assign bus.redirectPC = state_q == REDIR ? target_q : rpc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= 32'h3000_0000;
      epc_q    <= '0;
      int_q    <= '0;
      target_q <= '0;
      rpc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && take) begin
        epc_q <= bus.pc;
        int_q <= pend;
      end
      if (state_q == W_STATUS) target_q <= HANDLER_PC;
      if (state_q == E_RD) target_q <= bus.cp0Dout;
      if (state_q == REDIR) rpc_q <= target_q;
      if (wen != 2'b00 && reg_num == 5'd12) shadow_q <= din;
    end
  end
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb_cp0_exception_ctrl: scenario tasks checked against a queue-of-expected-CP0-operations reference model
module tb_cp0_exception_ctrl;
  localparam logic [31:0] HPC = 32'h0000_4180;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cp0_exception_ctrl_if bus ();
  cp0_exception_ctrl #(.HANDLER_PC(HPC)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] rf [32];
  always @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (bus.cp0WEn != 2'b00) rf[bus.cp0RegNum] <= bus.cp0Din;
  assign bus.cp0Dout = rf[bus.cp0RegNum];
  // k: 0 = CP0 write, 1 = CP0 read, 2 = redirect pulse with target d
  typedef struct packed {logic [1:0] k; logic [4:0] r; logic [31:0] d;} op_t;
  op_t q[$];
  logic [31:0] m_shadow = 32'h3000_0000;
  logic [31:0] m_rpc = '0;
  int n_chk = 0;
  int n_fail = 0;
  logic [72:0] obs, e, m;
  assign obs = {bus.stall, bus.redirect, bus.cp0WEn, bus.cp0RegNum, bus.cp0Din, bus.redirectPC};
  function automatic void model_cycle();
    op_t op;
    logic [5:0] pend;
    logic tk;
    e = '0;
    m = '1;
    if (rst) begin
      e[70:32] = {bus.dpWEn, bus.dpRegNum, bus.dpDin};
      m[31:0] = '0;
      q.delete();
      m_shadow = 32'h3000_0000;
      m_rpc = '0;
    end else if (q.size() != 0) begin
      op = q.pop_front();
      if (op.k == 2'd2) begin
        e[71] = 1'b1;
        e[31:0] = op.d;
        m[68:32] = '0;
        m_rpc = op.d;
      end else begin
        e[72] = 1'b1;
        e[70:64] = {(op.k == 2'd0) ? 2'b01 : 2'b00, op.r};
        e[63:32] = op.d;
        e[31:0] = m_rpc;
        if (op.k == 2'd1) m[63:32] = '0;
        if (op.k == 2'd0 && op.r == 5'd12) m_shadow = op.d;
      end
    end else begin
      pend = bus.hwInt & m_shadow[15:10];
      tk = (|pend) && m_shadow[0] && !m_shadow[1];
      e[31:0] = m_rpc;
      if (tk || bus.eret) begin
        e[72] = 1'b1;
        m[68:32] = '0;
        if (tk) begin
          q.push_back(op_t'{2'd0, 5'd14, bus.pc});
          q.push_back(op_t'{2'd0, 5'd13, {16'b0, pend, 10'b0}});
          q.push_back(op_t'{2'd0, 5'd12, m_shadow | 32'h2});
          q.push_back(op_t'{2'd2, 5'd0, HPC});
        end else begin
          q.push_back(op_t'{2'd1, 5'd14, 32'd0});
          q.push_back(op_t'{2'd0, 5'd12, m_shadow & ~32'h2});
          q.push_back(op_t'{2'd2, 5'd0, rf[14]});
        end
      end else begin
        e[70:32] = {bus.dpWEn, bus.dpRegNum, bus.dpDin};
        if (bus.dpWEn != 2'b00 && bus.dpRegNum == 5'd12) m_shadow = bus.dpDin;
      end
    end
  endfunction
  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic set_status(input logic [31:0] v);
    bus.dpRegNum = 5'd12; bus.dpDin = v; bus.dpWEn = 2'b01;
    sample();
    n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL set_status got=%h exp=%h", obs & m, e & m); end
    next();
    bus.dpWEn = 2'b00; bus.dpRegNum = 5'd3;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.hwInt = '1; bus.eret = 1'b1; bus.pc = $urandom;
      bus.dpRegNum = 5'($urandom); bus.dpDin = $urandom; bus.dpWEn = 2'($urandom);
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL reset_passthru got=%h exp=%h", obs & m, e & m); end
      n_chk++; if ({bus.stall, bus.redirect} !== 2'b00) begin n_fail++; $display("FAIL reset_quiet got=%b exp=00", {bus.stall, bus.redirect}); end
      next();
    end
    rst = 1'b0; bus.hwInt = '0; bus.eret = 1'b0; bus.dpWEn = 2'b10; bus.dpRegNum = 5'd7;
    sample();
    n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL after_reset got=%h exp=%h", obs & m, e & m); end
    n_chk++; if (bus.redirectPC !== 32'h0) begin n_fail++; $display("FAIL reset_rpc got=%h exp=0", bus.redirectPC); end
    next();
    bus.dpWEn = 2'b00;
  endtask
  task automatic test_int_entry();
    int at = -1;
    set_status(32'h0000_0401);
    bus.hwInt = 6'b000001; bus.pc = 32'h0000_3010;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) bus.hwInt = '1;
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL int_entry c=%0d got=%h exp=%h", c, obs & m, e & m); end
      if (bus.redirect && at < 0) at = c;
      next();
    end
    bus.hwInt = '0;
    n_chk++; if (at != 4) begin n_fail++; $display("FAIL int_latency got=%0d exp=4", at); end
    n_chk++; if (rf[14] !== 32'h0000_3010) begin n_fail++; $display("FAIL int_epc got=%h exp=00003010", rf[14]); end
    n_chk++; if (rf[13] !== 32'h0000_0400) begin n_fail++; $display("FAIL int_cause got=%h exp=00000400", rf[13]); end
    n_chk++; if (rf[12] !== 32'h0000_0403) begin n_fail++; $display("FAIL int_status got=%h exp=00000403", rf[12]); end
    n_chk++; if (bus.redirectPC !== HPC) begin n_fail++; $display("FAIL int_rpc_hold got=%h exp=%h", bus.redirectPC, HPC); end
  endtask
  task automatic test_eret();
    int at = -1;
    bus.eret = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL eret c=%0d got=%h exp=%h", c, obs & m, e & m); end
      if (bus.redirect && at < 0) begin
        at = c;
        n_chk++; if (bus.redirectPC !== 32'h0000_3010) begin n_fail++; $display("FAIL eret_target got=%h exp=00003010", bus.redirectPC); end
      end
      next();
      bus.eret = 1'b0;
    end
    n_chk++; if (at != 3) begin n_fail++; $display("FAIL eret_latency got=%0d exp=3", at); end
    n_chk++; if (rf[12] !== 32'h0000_0401) begin n_fail++; $display("FAIL eret_status got=%h exp=00000401", rf[12]); end
  endtask
  task automatic test_masking();
    logic [31:0] cfg [2];
    cfg[0] = 32'h0000_fc00;
    cfg[1] = 32'h0000_0001;
    for (int s = 0; s < 2; s++) begin
      set_status(cfg[s]);
      bus.hwInt = '1;
      for (int c = 0; c < 10; c++) begin
        bus.dpRegNum = 5'($urandom_range(11)); bus.dpDin = $urandom; bus.dpWEn = 2'($urandom); bus.pc = $urandom;
        sample();
        n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL masked s=%0d got=%h exp=%h", s, obs & m, e & m); end
        n_chk++; if ({bus.stall, bus.redirect} !== 2'b00) begin n_fail++; $display("FAIL masked_quiet s=%0d got=%b exp=00", s, {bus.stall, bus.redirect}); end
        next();
      end
      bus.hwInt = '0; bus.dpWEn = 2'b00;
    end
  endtask
  task automatic test_int_eret();
    int reds = 0;
    logic [31:0] pc_r = $urandom, tgt = '0;
    set_status(32'h0000_fc01);
    bus.hwInt = 6'b000100; bus.eret = 1'b1; bus.pc = pc_r;
    for (int c = 0; c < 8; c++) begin
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL int_eret c=%0d got=%h exp=%h", c, obs & m, e & m); end
      if (bus.redirect) begin reds++; tgt = bus.redirectPC; end
      next();
      bus.eret = 1'b0;
    end
    n_chk++; if (reds != 1 || tgt !== HPC) begin n_fail++; $display("FAIL int_eret_redirect got=%0d/%h exp=1/%h", reds, tgt, HPC); end
    n_chk++; if (rf[14] !== pc_r) begin n_fail++; $display("FAIL int_eret_epc got=%h exp=%h", rf[14], pc_r); end
    n_chk++; if (rf[13] !== 32'h0000_1000) begin n_fail++; $display("FAIL int_eret_cause got=%h exp=00001000", rf[13]); end
    bus.hwInt = '0; bus.eret = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL int_eret_ret c=%0d got=%h exp=%h", c, obs & m, e & m); end
      next();
      bus.eret = 1'b0;
    end
    n_chk++; if (bus.redirectPC !== pc_r) begin n_fail++; $display("FAIL int_eret_return got=%h exp=%h", bus.redirectPC, pc_r); end
  endtask
  task automatic test_reset_mid();
    int reds = 0, swr = 0, stl = 0;
    set_status(32'h0000_0401);
    bus.hwInt = 6'b000001; bus.pc = $urandom;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) rst = 1'b1;
      if (c == 3) begin rst = 1'b0; bus.hwInt = '1; end
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs & m, e & m); end
      if (bus.redirect) reds++;
      if (bus.cp0WEn != 2'b00 && bus.cp0RegNum == 5'd12) swr++;
      if (c >= 2 && bus.stall) stl++;
      next();
    end
    bus.hwInt = '0;
    n_chk++; if (reds != 0) begin n_fail++; $display("FAIL reset_mid_redirect got=%0d exp=0", reds); end
    n_chk++; if (swr != 0) begin n_fail++; $display("FAIL reset_mid_status_write got=%0d exp=0", swr); end
    n_chk++; if (stl != 0) begin n_fail++; $display("FAIL reset_mid_stall got=%0d exp=0", stl); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) == 0);
      bus.hwInt = 6'($urandom) & 6'($urandom);
      bus.eret = ($urandom_range(7) == 0);
      bus.pc = $urandom;
      bus.dpRegNum = ($urandom_range(3) == 0) ? 5'd12 : 5'($urandom);
      bus.dpDin = $urandom;
      bus.dpWEn = 2'($urandom);
      sample();
      n_chk++; if ((obs & m) !== (e & m)) begin n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, obs & m, e & m); end
      next();
    end
    rst = 1'b0;
  endtask
  initial begin
    bus.hwInt = '0; bus.pc = '0; bus.eret = 1'b0;
    bus.dpRegNum = '0; bus.dpDin = '0; bus.dpWEn = '0;
    test_reset();
    test_int_entry();
    test_eret();
    test_masking();
    test_int_eret();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_exception_ctrl.md
CP0_EXCEPTION_CTRL -- requirements
Module: cp0_exception_ctrl

Interface
REQ-001 HANDLER_PC, 32'h0000_4180, interrupt handler entry address driven on redirect.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 hwInt  input  6  level-sensitive hardware interrupt lines; bit i maps to Status IM bit 10+i.
REQ-005 pc  input  32  PC of the instruction currently eligible for interruption.
REQ-006 eret  input  1  decoded ERET, valid for one cycle while not stalled.
REQ-007 dpRegNum / dpDin / dpWEn  input  5 / 32 / 2  datapath CP0 access request (mfc0/mtc0).
REQ-008 cp0Dout  input  32  CP0 register file read data for cp0RegNum (combinational).
REQ-009 cp0RegNum / cp0Din / cp0WEn  output  5 / 32 / 2  CP0 register file access port.
REQ-010 stall  output  1  freeze pipeline while the block owns the CP0 port.
REQ-011 redirect  output  1  one-cycle pulse: fetch from redirectPC.
REQ-012 redirectPC  output  32  redirect target.

Function
REQ-013 The block SHALL hold a shadow Status register, updated with cp0Din on every cycle in which cp0WEn!=0 and cp0RegNum==12.
REQ-014 Interrupt condition int = |(hwInt & shadow[15:10]) & shadow[0] (IE) & ~shadow[1] (EXL).
REQ-015 FSM states: IDLE, W_EPC, W_CAUSE, W_STATUS, E_RD, E_WR, REDIR.
REQ-016 IDLE without int or eret: cp0RegNum/cp0Din/cp0WEn SHALL equal dpRegNum/dpDin/dpWEn combinationally; stall=0, redirect=0.
REQ-017 IDLE with int: latch pc into epcLat and (hwInt & shadow[15:10]) into intLat; stall=1 same cycle; cp0WEn forced 0 (datapath write suppressed); next state W_EPC.
REQ-018 Interrupt wins over a simultaneous eret; eret is dropped and re-executes after handler return.
REQ-019 IDLE with eret and no int: stall=1, cp0WEn=0; next state E_RD.
REQ-020 W_EPC: cp0RegNum=14, cp0Din=epcLat, cp0WEn=2'b01, stall=1; next W_CAUSE.
REQ-021 W_CAUSE: cp0RegNum=13, cp0Din={16'b0, intLat, 10'b0}, cp0WEn=2'b01, stall=1; next W_STATUS.
REQ-022 W_STATUS: cp0RegNum=12, cp0Din=shadow | 32'h2 (EXL set), cp0WEn=2'b01, stall=1; target register <= HANDLER_PC; next REDIR.
REQ-023 E_RD: cp0RegNum=14, cp0WEn=0, stall=1; target register <= cp0Dout; next E_WR.
REQ-024 E_WR: cp0RegNum=12, cp0Din=shadow & ~32'h2 (EXL cleared), cp0WEn=2'b01, stall=1; next REDIR.
REQ-025 REDIR: redirect=1, redirectPC=target, stall=0, cp0WEn=0; next IDLE unconditionally.
REQ-026 Interrupt entry latency: detect cycle to redirect pulse = 4 cycles; ERET: 3 cycles.
REQ-027 In all non-IDLE states datapath dpWEn SHALL be ignored; hwInt changes after latch SHALL not alter intLat.
REQ-028 Nested interrupts SHALL not be taken while EXL=1; re-enable only via E_WR.
REQ-029 redirectPC SHALL hold its last value outside REDIR.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, shadow=32'h3000_0000, epcLat=0, intLat=0, target=0.
REQ-031 During reset cycles and the cycle after: stall=0, redirect=0, cp0WEn=dpWEn passthrough (IDLE); rst mid-sequence SHALL abandon remaining CP0 writes.

Verification
REQ-032 mtc0 Status=32'h0000_0401 (IM0, IE) then hwInt=6'b000001, pc=32'h0000_3010 -> writes EPC=0000_3010, Cause=0000_0400, Status=0000_0403, redirect with 0000_4180 four cycles after detect.
REQ-033 After REQ-032, eret -> EPC read, Status write 0000_0401, redirect to 0000_3010 three cycles after eret.
REQ-034 Status IE=0 or IM masking hwInt, hwInt=6'b111111 -> no stall, no redirect, datapath passthrough intact.
REQ-035 int and eret same cycle -> interrupt sequence only, EPC=pc of ERET instruction.
REQ-036 rst asserted in W_CAUSE -> no Status write, state IDLE, shadow=3000_0000, redirect never pulses.
